mips_decode_regfile_alu: RTL and testbench
==========================================

Name: mips_decode_regfile_alu

Overview:
Single-cycle MIPS decode, register-file and ALU slice. It takes one 32-bit instruction and decodes it. It reads rs/rt from a 32x32 register file and produces the ALU result (`finalOut`) and the zero flag combinationally. R-type results are written back to rd on the clock edge. It sits between instruction fetch and data memory / branch logic; memory access itself is outside this block.

Parameters:
- DATA_W, 32, datapath and register width (only 32 supported).
- NREGS, 32, register count (only 32 supported; 5-bit specifiers).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- instruction  input  32  instruction word: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0].
- finalOut  output  32  ALU result (combinational).
- zeroFlag  output  1  high when finalOut == 0 (combinational).

Behaviour:
- Decode by opcode:
  - 000000 R-type: ALU op comes from funct, rd written back.
  - 100011 lw: rs + sext(imm), no write-back.
  - 101011 sw: rs + sext(imm), no write-back.
  - 000100 beq: rs − rt, no write-back.
  - Any other opcode: finalOut = 0, zeroFlag = 1, no write.
- R-type funct:
  - 100000 add.
  - 100010 sub.
  - 100100 and.
  - 100101 or.
  - 100111 nor.
  - 101010 slt (signed, result 1/0).
  - Any other funct: result 0, no write.
  - shamt ignored.
- Arithmetic: 32-bit two's complement, wrap-around, no overflow trap or flag.
- Sign extension: imm[15] replicated into [31:16].
- Latency: finalOut/zeroFlag are purely combinational from `instruction` and current register contents, valid within the same cycle. No handshake.
- Register file: two asynchronous read ports (rs, rt) and one synchronous write port (rd).
- Write-back:
  - Occurs at rising clk when rst=0, the instruction is a supported R-type, and rd != 0.
  - Register 0 always reads 0; writes to it are ignored.
- Read during write to the same register: returns the old value until the edge (no bypass).
- Reset:
  - At rising clk with rst=1, register[i] <= i for i = 0..31 (so $18 = 18, $19 = 19).
  - Reset overrides any simultaneous write; reset mid-operation discards the pending write.
- Before the first reset, register contents are undefined. The bench must apply reset first.

Decomposition:
- Package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT;
  - an ALU-operation enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_ZERO).
- One natural sub-module: mips_alu. Inputs a, b and alu_op; outputs result and zero. Decode and register file stay in the top.

Test Plan:
- Reset then lw: instruction 100011_10010_10011_0000000000010100 -> finalOut = 38, zeroFlag = 0, no register change.
- sw with imm 30, rs = 18 -> finalOut = 48, zeroFlag = 0.
- R-type on rs = 18, rt = 19 (rd = 16):
  - add (funct 100000) -> 37.
  - and (funct 100100) -> 18.
  - or (funct 100101) -> 19.
  - After each clock edge, $16 holds that result.
  - Verify by issuing or rs = 16, rt = 0 -> finalOut equals the last result.
- beq rs = 18, rt = 19, imm 65 -> finalOut = 0xFFFFFFFF, zeroFlag = 0; beq rs = 18, rt = 18 -> finalOut = 0, zeroFlag = 1.
- Edge cases:
  - sub 0 − 1 wraps to 0xFFFFFFFF.
  - slt rs = 18, rt = 19 -> 1; reversed -> 0.
  - R-type with rd = 0 leaves $0 = 0.
  - Unknown opcode 111111 -> finalOut = 0, zeroFlag = 1, no write.
- Reset: after writing $16 = 37, assert rst for one edge while an add is presented -> $16 = 16, and the add result is not written.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode / register-file / ALU slice:
// opcode and funct constants, the ALU operation enum and funct decoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_ZERO
    } alu_op_e;

    // Unsupported funct codes map to ALU_ZERO, which also suppresses write-back.
    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            F_ADD:   return ALU_ADD;
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_NOR:   return ALU_NOR;
            F_SLT:   return ALU_SLT;
            default: return ALU_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU: wrap-around add/sub, bitwise ops, signed slt.
import mips_pkg::*;

module mips_alu #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_regfile_alu.sv
// Single-cycle decode, 32x32 register file (2 async reads, 1 sync write) and ALU.
// Only supported R-type instructions with rd != 0 write back.
import mips_pkg::*;

module mips_decode_regfile_alu #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    output logic [DATA_W-1:0] finalOut,
    output logic              zeroFlag
);

    logic [DATA_W-1:0] r_regs [NREGS];

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_sext_imm;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic [DATA_W-1:0] w_alu_b;
    alu_op_e           w_alu_op;
    logic              w_rtype_ok;
    logic              w_wr_en;
    logic              w_unused_shamt;

    assign w_opcode       = instruction[31:26];
    assign w_rs           = instruction[25:21];
    assign w_rt           = instruction[20:16];
    assign w_rd           = instruction[15:11];
    assign w_funct        = instruction[5:0];
    assign w_imm          = instruction[15:0];
    assign w_unused_shamt = ^instruction[10:6];
    assign w_sext_imm     = {{(DATA_W-16){w_imm[15]}}, w_imm};

    // $0 is hardwired to zero on the read side regardless of array contents.
    assign w_rs_data = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

    always_comb begin
        w_alu_op   = ALU_ZERO;
        w_alu_b    = w_rt_data;
        w_rtype_ok = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_alu_op   = funct_to_alu(w_funct);
                w_rtype_ok = (funct_to_alu(w_funct) != ALU_ZERO);
            end
            OP_LW, OP_SW: begin
                w_alu_op = ALU_ADD;
                w_alu_b  = w_sext_imm;
            end
            OP_BEQ: w_alu_op = ALU_SUB;
            default: w_alu_op = ALU_ZERO;
        endcase
    end

    assign w_wr_en = w_rtype_ok && (w_rd != 5'd0);

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (w_rs_data),
        .b      (w_alu_b),
        .alu_op (w_alu_op),
        .result (finalOut),
        .zero   (zeroFlag)
    );

    // Reset preloads register[i] = i and wins over any write presented that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else if (w_wr_en) begin
            r_regs[w_rd] <= finalOut;
        end
    end

endmodule

// File: tb/tb_mips_decode_regfile_alu.sv
// Scoreboard bench: directed plan values plus randomized instructions checked
// against an arithmetic reference model of the register file.
module tb_mips_decode_regfile_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] finalOut;
    logic        zeroFlag;

    mips_decode_regfile_alu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .finalOut    (finalOut),
        .zeroFlag    (zeroFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_regs [32];
    bit          model_valid = 1'b0;

    // Reference: compute result and write decision from the instruction rules.
    function automatic logic [31:0] model_exec(input logic [31:0] ins, output bit wr);
        logic [31:0] a, b, sx;
        a  = model_regs[ins[25:21]];
        b  = model_regs[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        wr = 1'b0;
        case (ins[31:26])
            6'd0: begin
                wr = (ins[15:11] != 5'd0);
                case (ins[5:0])
                    6'd32: return a + b;
                    6'd34: return a - b;
                    6'd36: return a & b;
                    6'd37: return a | b;
                    6'd39: return ~(a | b);
                    6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin
                        wr = 1'b0;
                        return 32'd0;
                    end
                endcase
            end
            6'd35, 6'd43: return a + sx;
            6'd4:         return a - b;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Present one instruction for a cycle; use_exp selects a hard-coded expectation.
    task automatic issue(input logic [31:0] ins, input logic r, input bit use_exp, input logic [31:0] exp_v);
        logic [31:0] m;
        bit          wr;
        exp_t        e;
        instruction = ins;
        rst         = r;
        if (model_valid) begin
            m       = model_exec(ins, wr);
            e.instr = ins;
            e.res   = use_exp ? exp_v : m;
            e.zero  = (e.res == 32'd0);
            sb_q.push_back(e);
        end else begin
            wr = 1'b0;
            m  = '0;
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'(i);
            model_valid = 1'b1;
        end else if (model_valid && wr) begin
            model_regs[ins[15:11]] = m;
        end
        #1;
    endtask

    task automatic readback(input int r, input logic [31:0] exp_v);
        issue(rtype(r, 0, 0, 6'b100101), 1'b0, 1'b1, exp_v);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_checks++;
            if (finalOut !== cur.res) begin
                n_fail++;
                $display("FAIL finalOut instr=%h actual=%h required=%h", cur.instr, finalOut, cur.res);
            end
            n_checks++;
            if (zeroFlag !== cur.zero) begin
                n_fail++;
                $display("FAIL zeroFlag instr=%h actual=%b required=%b", cur.instr, zeroFlag, cur.zero);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  f;
        int          sel;
        logic [5:0]  functs [6];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b100111; functs[5] = 6'b101010;

        issue(32'd0, 1'b1, 1'b0, '0);
        issue(32'd0, 1'b1, 1'b1, 32'd0);

        issue(32'b100011_10010_10011_0000000000010100, 1'b0, 1'b1, 32'd38);
        readback(19, 32'd19);
        issue(itype(6'b101011, 18, 19, 16'd30), 1'b0, 1'b1, 32'd48);
        issue(rtype(18, 19, 16, 6'b100000), 1'b0, 1'b1, 32'd37);
        readback(16, 32'd37);
        issue(rtype(18, 19, 16, 6'b100100), 1'b0, 1'b1, 32'd18);
        readback(16, 32'd18);
        issue(rtype(18, 19, 16, 6'b100101), 1'b0, 1'b1, 32'd19);
        readback(16, 32'd19);
        issue(itype(6'b000100, 18, 19, 16'd65), 1'b0, 1'b1, 32'hFFFF_FFFF);
        issue(itype(6'b000100, 18, 18, 16'd65), 1'b0, 1'b1, 32'd0);
        issue(rtype(0, 1, 5, 6'b100010), 1'b0, 1'b1, 32'hFFFF_FFFF);
        readback(5, 32'hFFFF_FFFF);
        issue(rtype(18, 19, 7, 6'b101010), 1'b0, 1'b1, 32'd1);
        issue(rtype(19, 18, 7, 6'b101010), 1'b0, 1'b1, 32'd0);
        readback(7, 32'd0);
        issue(rtype(18, 19, 0, 6'b100000), 1'b0, 1'b1, 32'd37);
        readback(0, 32'd0);
        issue(itype(6'b111111, 18, 17, 16'h0840), 1'b0, 1'b1, 32'd0);
        readback(17, 32'd17);
        issue(rtype(18, 19, 16, 6'b100000), 1'b0, 1'b1, 32'd37);
        readback(16, 32'd37);
        issue(rtype(1, 2, 16, 6'b100000), 1'b1, 1'b1, 32'd3);
        readback(16, 32'd16);
        readback(5, 32'd5);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                f   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
                ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f);
                ins[10:6] = 5'($urandom);
            end else if (sel == 5) begin
                ins = itype(6'b100011, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
            end else if (sel == 6) begin
                ins = itype(6'b101011, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
            end else if (sel == 7) begin
                ins = itype(6'b000100, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
            end else begin
                ins = $urandom;
            end
            issue(ins, ($urandom_range(0, 49) == 0), 1'b0, '0);
        end

        for (int r = 0; r < 32; r++) readback(r, model_regs[r]);

        instruction = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
